// File: rtl/if_pkg.sv
// if_pkg: shared types for the instruction-fetch unit.
// Holds the fetch FSM state encoding and the NOP word.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2
   } if_state_e;

   localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_timeout_cnt.sv
// if_timeout_cnt: saturating cycle counter with clear/enable and expiry flag.
// Ports: clk, rst (sync, active-high), clr, en -> expired (cnt == MAX-1).
// MAX = 0 disables expiry; the counter then stays at zero.
module if_timeout_cnt #(
   parameter int unsigned MAX = 16,
   localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] SAT  = W'(MAX);
   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (MAX != 0) && (cnt_q == LAST);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC -> IMEM req/ack read -> decode valid/ready, with flush
// and memory timeout. Optional IF_ALIGN_CHECK_EN adds ALIGN_ERR output.
// Ports: PC_IN/PC_VALID/PC_READY in, IMEM_* memory, INSTR_* to decode,
// FLUSH, TIMEOUT_ERR (1-cycle pulse).
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] PC_IN,
   input  logic              PC_VALID,
   output logic              PC_READY,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic              IMEM_REQ,
   input  logic              IMEM_ACK,
   input  logic [DATA_W-1:0] IMEM_RDATA,
   output logic [DATA_W-1:0] INSTR_OUT,
   output logic [ADDR_W-1:0] INSTR_PC,
   output logic              INSTR_VALID,
   input  logic              INSTR_READY,
   input  logic              FLUSH,
`ifdef IF_ALIGN_CHECK_EN
   output logic              ALIGN_ERR,
`endif
   output logic              TIMEOUT_ERR
);

   if_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              disc_q, disc_d;
   logic              tmo_q, tmo_d;
   logic              accept;
   logic              cnt_en;
   logic              tmo_hit;
`ifdef IF_ALIGN_CHECK_EN
   logic              algn_q, algn_d;
`endif

   if_timeout_cnt #(.MAX(TIMEOUT_CYC)) u_tmo (
      .clk     (CLK),
      .rst     (RESET),
      .clr     (accept),
      .en      (cnt_en),
      .expired (tmo_hit)
   );

   // No acceptance while reset is held, so every output reads 0 then.
   assign PC_READY = (state_q == IDLE) && !FLUSH && !RESET;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      disc_d  = disc_q;
      tmo_d   = 1'b0;
      accept  = 1'b0;
      cnt_en  = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      algn_d  = algn_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (PC_VALID && PC_READY) begin
               accept  = 1'b1;
               addr_d  = PC_IN;
               state_d = REQ;
`ifdef IF_ALIGN_CHECK_EN
               // Misaligned PC: skip memory, hand decode a NOP.
               if (PC_IN[1:0] != 2'b00) begin
                  state_d = OUT;
                  instr_d = DATA_W'(NOP);
                  algn_d  = 1'b1;
               end
`endif
            end
         end
         REQ: begin
            if (FLUSH) begin
               disc_d = 1'b1;
            end
            if (IMEM_ACK) begin
               disc_d = 1'b0;
               // A flush seen now or earlier drops the returned word.
               if (disc_q || FLUSH) begin
                  state_d = IDLE;
               end else begin
                  instr_d = IMEM_RDATA;
                  state_d = OUT;
               end
            end else if (tmo_hit) begin
               disc_d  = 1'b0;
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         OUT: begin
            if (INSTR_READY || FLUSH) begin
               state_d = IDLE;
`ifdef IF_ALIGN_CHECK_EN
               algn_d  = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         disc_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         disc_q  <= disc_d;
         tmo_q   <= tmo_d;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         algn_q <= 1'b0;
      end else begin
         algn_q <= algn_d;
      end
   end

   assign ALIGN_ERR = algn_q;
`endif

   assign IMEM_REQ    = (state_q == REQ);
   assign IMEM_ADDR   = addr_q;
   assign INSTR_VALID = (state_q == OUT);
   assign INSTR_OUT   = instr_q;
   assign INSTR_PC    = addr_q;
   assign TIMEOUT_ERR = tmo_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + randomized fetch transactions, each checked
// against the outcome (deliver / drop / timeout) predicted from the rules.
module tb_if_fetch_unit;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [AW-1:0] PC_IN;
   logic          PC_VALID;
   logic          PC_READY;
   logic [AW-1:0] IMEM_ADDR;
   logic          IMEM_REQ;
   logic          IMEM_ACK;
   logic [DW-1:0] IMEM_RDATA;
   logic [DW-1:0] INSTR_OUT;
   logic [AW-1:0] INSTR_PC;
   logic          INSTR_VALID;
   logic          INSTR_READY;
   logic          FLUSH;
   logic          TIMEOUT_ERR;
`ifdef IF_ALIGN_CHECK_EN
   logic          ALIGN_ERR;
`endif

   if_fetch_unit #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PC_IN       (PC_IN),
      .PC_VALID    (PC_VALID),
      .PC_READY    (PC_READY),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ACK    (IMEM_ACK),
      .IMEM_RDATA  (IMEM_RDATA),
      .INSTR_OUT   (INSTR_OUT),
      .INSTR_PC    (INSTR_PC),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .FLUSH       (FLUSH),
`ifdef IF_ALIGN_CHECK_EN
      .ALIGN_ERR   (ALIGN_ERR),
`endif
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_bad = 0;
   int n_del = 0;
   int n_err = 0;
   int exp_del = 0;
   int exp_err = 0;

   typedef enum {O_DELIVER, O_DROP, O_TIMEOUT} out_e;

   always @(posedge CLK) begin
      if (!RESET) begin
         if (INSTR_VALID && INSTR_READY) n_del++;
         if (TIMEOUT_ERR) n_err++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: hold inputs over the edge, then drop handshakes and settle.
   task automatic step;
      @(posedge CLK);
      #1;
      PC_VALID    = 1'b0;
      IMEM_ACK    = 1'b0;
      FLUSH       = 1'b0;
      INSTR_READY = 1'b0;
      #1;
   endtask

   // Outcome of one fetch from the rules: ack_at is the REQ cycle (1-based)
   // carrying ACK, fl_at the REQ cycle carrying FLUSH (0 = none).
   function automatic out_e outcome(input int ack_at, input int fl_at);
      if (ack_at < 1 || ack_at > TMO) return O_TIMEOUT;
      if (fl_at >= 1 && fl_at <= ack_at) return O_DROP;
      return O_DELIVER;
   endfunction

   task automatic run_txn(input logic [AW-1:0] pc, input logic [DW-1:0] data,
                          input int ack_at, input int fl_at, input int stall,
                          input bit out_fl, input bit out_rdy);
      out_e o;
      int   nreq;
      o    = outcome(ack_at, fl_at);
      nreq = (o == O_TIMEOUT) ? TMO : ack_at;
      chk("pc_ready_idle", PC_READY, 1);
      PC_IN    = pc;
      PC_VALID = 1'b1;
      step();
      PC_IN = $urandom;
      for (int k = 1; k <= nreq; k++) begin
         chk("imem_req", IMEM_REQ, 1);
         chk("imem_addr", IMEM_ADDR, pc);
         chk("valid_in_req", INSTR_VALID, 0);
         IMEM_ACK   = (k == ack_at);
         IMEM_RDATA = (k == ack_at) ? data : $urandom;
         FLUSH      = (k == fl_at);
         step();
      end
      chk("req_done", IMEM_REQ, 0);
      if (o == O_TIMEOUT) begin
         exp_err++;
         chk("tmo_pulse", TIMEOUT_ERR, 1);
         chk("tmo_valid", INSTR_VALID, 0);
         step();
         chk("tmo_one_cycle", TIMEOUT_ERR, 0);
      end else if (o == O_DROP) begin
         chk("drop_valid", INSTR_VALID, 0);
         chk("drop_idle", PC_READY, 1);
         chk("drop_noerr", TIMEOUT_ERR, 0);
      end else begin
         chk("out_valid", INSTR_VALID, 1);
         chk("out_data", INSTR_OUT, data);
         chk("out_pc", INSTR_PC, pc);
         chk("out_noerr", TIMEOUT_ERR, 0);
         for (int s = 0; s < stall; s++) begin
            PC_VALID = 1'b1;
            #1;
            chk("bp_pc_ready", PC_READY, 0);
            step();
            chk("bp_valid", INSTR_VALID, 1);
            chk("bp_data", INSTR_OUT, data);
            chk("bp_pc", INSTR_PC, pc);
            chk("bp_noreq", IMEM_REQ, 0);
         end
         if (out_fl) begin
            FLUSH       = 1'b1;
            INSTR_READY = out_rdy;
            if (out_rdy) exp_del++;
         end else begin
            INSTR_READY = 1'b1;
            exp_del++;
         end
         step();
         chk("done_valid", INSTR_VALID, 0);
         chk("done_ready", PC_READY, 1);
      end
   endtask

   initial begin
      RESET       = 1'b1;
      PC_IN       = '0;
      PC_VALID    = 1'b0;
      IMEM_ACK    = 1'b0;
      IMEM_RDATA  = '0;
      INSTR_READY = 1'b0;
      FLUSH       = 1'b0;
      step();
      step();
      chk("rst_pc_ready", PC_READY, 0);
      chk("rst_req", IMEM_REQ, 0);
      chk("rst_addr", IMEM_ADDR, 0);
      chk("rst_valid", INSTR_VALID, 0);
      chk("rst_out", INSTR_OUT, 0);
      chk("rst_err", TIMEOUT_ERR, 0);
      RESET = 1'b0;
      #1;

      run_txn(32'd20, 32'h2008_0005, 1, 0, 0, 0, 0);
      run_txn(32'd1024, $urandom, 5, 0, 0, 0, 0);
      run_txn(32'h40, $urandom, 2, 0, 4, 0, 0);
      run_txn(32'd256, $urandom, 4, 2, 0, 0, 0);
      run_txn(32'd260, $urandom, 1, 0, 0, 0, 0);
      run_txn(32'h80, $urandom, 0, 0, 0, 0, 0);
      run_txn(32'h84, $urandom, TMO, 0, 0, 0, 0);
      run_txn(32'h88, $urandom, 3, 0, 1, 1, 0);
      run_txn(32'h8c, $urandom, 1, 0, 0, 1, 1);

      FLUSH    = 1'b1;
      PC_VALID = 1'b1;
      #1;
      chk("idle_flush_ready", PC_READY, 0);
      step();
      chk("idle_flush_noreq", IMEM_REQ, 0);

      PC_IN    = 32'h100;
      PC_VALID = 1'b1;
      step();
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 32'hdead_beef;
      step();
      chk("mid_out_valid", INSTR_VALID, 1);
      RESET = 1'b1;
      step();
      chk("mrst_valid", INSTR_VALID, 0);
      chk("mrst_out", INSTR_OUT, 0);
      chk("mrst_pc", INSTR_PC, 0);
      chk("mrst_req", IMEM_REQ, 0);
      chk("mrst_ready", PC_READY, 0);
      RESET = 1'b0;
      #1;
      chk("mrst_idle", PC_READY, 1);

`ifdef IF_ALIGN_CHECK_EN
      PC_IN    = 32'd22;
      PC_VALID = 1'b1;
      step();
      chk("algn_noreq", IMEM_REQ, 0);
      chk("algn_valid", INSTR_VALID, 1);
      chk("algn_nop", INSTR_OUT, 0);
      chk("algn_err", ALIGN_ERR, 1);
      INSTR_READY = 1'b1;
      exp_del++;
      step();
      chk("algn_clr", ALIGN_ERR, 0);
`endif

      for (int i = 0; i < 60; i++) begin
         int ack_at, fl_at, stall;
         bit out_fl, out_rdy;
         ack_at = $urandom_range(0, TMO + 1);
         fl_at  = 0;
         if (ack_at >= 2 && $urandom_range(0, 3) == 0)
            fl_at = $urandom_range(1, ack_at - 1);
         stall   = $urandom_range(0, 3);
         out_fl  = ($urandom_range(0, 3) == 0);
         out_rdy = 1'($urandom_range(0, 1));
         run_txn({$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom,
                 ack_at, fl_at, stall, out_fl, out_rdy);
      end

      chk("deliveries", n_del, exp_del);
      chk("tmo_pulses", n_err, exp_err);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
